// File: rtl/pipe_regfile.sv
// Architectural register file: NUM_REGS x DATA_WIDTH, one write port, two combinational read ports.
// Define RF_BYPASS_EN to forward same-cycle write data to matching read ports.
module pipe_regfile #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  w_we;

  assign w_we = RegWrite && (WriteRegister != ZERO_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[WriteRegister] <= WriteData;
    end
  end

`ifdef RF_BYPASS_EN
  logic w_byp1;
  logic w_byp2;

  // Forwarding is qualified by w_we, so the zero register is never bypassed.
  assign w_byp1 = !reset && w_we && (WriteRegister == ReadRegister1);
  assign w_byp2 = !reset && w_we && (WriteRegister == ReadRegister2);

  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (ReadRegister1 != ZERO_IDX) begin
      ReadData1 = w_byp1 ? WriteData : r_regs[ReadRegister1];
    end
    if (ReadRegister2 != ZERO_IDX) begin
      ReadData2 = w_byp2 ? WriteData : r_regs[ReadRegister2];
    end
  end
`else
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (ReadRegister1 != ZERO_IDX) begin
      ReadData1 = r_regs[ReadRegister1];
    end
    if (ReadRegister2 != ZERO_IDX) begin
      ReadData2 = r_regs[ReadRegister2];
    end
  end
`endif

endmodule

// File: tb/tb_pipe_regfile.sv
// Self-checking bench for pipe_regfile: array model checked every cycle plus directed literal checks.
module tb_pipe_regfile;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  int checks   = 0;
  int failures = 0;

  logic [63:0] model [32];
  bit          model_valid = 0;

  pipe_regfile #(
    .DATA_WIDTH(64),
    .ADDR_WIDTH(5),
    .NUM_REGS(32),
    .ZERO_REG(31)
  ) dut (
    .clk(clk),
    .reset(reset),
    .RegWrite(RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData(WriteData),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Architectural state: what every register must hold after each edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] <= 64'd0;
      model_valid <= 1;
    end else if (RegWrite && WriteRegister != 5'd31) begin
      model[WriteRegister] <= WriteData;
    end
  end

  function automatic logic [63:0] expect_rd(input logic [4:0] idx);
    if (idx == 5'd31) return 64'd0;
`ifdef RF_BYPASS_EN
    if (!reset && RegWrite && WriteRegister == idx) return WriteData;
`endif
    return model[idx];
  endfunction

  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_rd1", ReadData1, expect_rd(ReadRegister1));
      chk("model_rd2", ReadData2, expect_rd(ReadRegister2));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] V5 = 64'h0123456789ABCDEF;

  initial begin
    reset = 1; RegWrite = 0; WriteRegister = 0; WriteData = 0;
    ReadRegister1 = 0; ReadRegister2 = 0;
    next_cycle();
    reset = 0;

    // 1: every index reads zero after reset
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      @(negedge clk);
      chk("t1_rd1_zero", ReadData1, 64'd0);
      chk("t1_rd2_zero", ReadData2, 64'd0);
      next_cycle();
    end

    // 2: write X5, read back on both ports
    RegWrite = 1; WriteRegister = 5; WriteData = V5;
    next_cycle();
    RegWrite = 0; ReadRegister1 = 5; ReadRegister2 = 5;
    @(negedge clk);
    chk("t2_x5_rd1", ReadData1, V5);
    chk("t2_x5_rd2", ReadData2, V5);
    ReadRegister2 = 6;
    @(negedge clk);
    chk("t2_x6_rd2", ReadData2, 64'd0);
    next_cycle();

    // 3: writes to the zero register are discarded
    RegWrite = 1; WriteRegister = 31; WriteData = '1;
    ReadRegister1 = 31; ReadRegister2 = 30;
    @(negedge clk);
    chk("t3_x31_during", ReadData1, 64'd0);
    next_cycle();
    RegWrite = 0; ReadRegister1 = 31; ReadRegister2 = 0;
    @(negedge clk);
    chk("t3_x31_after", ReadData1, 64'd0);
    chk("t3_x0", ReadData2, 64'd0);
    next_cycle();
    ReadRegister1 = 30; ReadRegister2 = 5;
    @(negedge clk);
    chk("t3_x30", ReadData1, 64'd0);
    chk("t3_x5_kept", ReadData2, V5);
    next_cycle();

    // 4: read-during-write on X7
    RegWrite = 1; WriteRegister = 7; WriteData = 64'hAA;
    next_cycle();
    WriteData = 64'h55; ReadRegister1 = 7; ReadRegister2 = 31;
    @(negedge clk);
`ifdef RF_BYPASS_EN
    chk("t4_same_cycle", ReadData1, 64'h55);
`else
    chk("t4_same_cycle", ReadData1, 64'hAA);
`endif
    chk("t4_zero_no_byp", ReadData2, 64'd0);
    next_cycle();
    RegWrite = 0;
    @(negedge clk);
    chk("t4_after_edge", ReadData1, 64'h55);
    next_cycle();

    // 5: reset overrides a simultaneous write
    reset = 1; RegWrite = 1; WriteRegister = 3; WriteData = 64'h99;
    ReadRegister1 = 3; ReadRegister2 = 5;
    @(negedge clk);
    chk("t5_no_byp_in_reset", ReadData1, 64'd0);
    chk("t5_x5_before", ReadData2, V5);
    next_cycle();
    reset = 0; RegWrite = 0;
    @(negedge clk);
    chk("t5_x3_cleared", ReadData1, 64'd0);
    chk("t5_x5_cleared", ReadData2, 64'd0);
    next_cycle();
    ReadRegister1 = 7;
    RegWrite = 1; WriteRegister = 2; WriteData = 64'h42; ReadRegister2 = 2;
    @(negedge clk);
    chk("t5_x7_cleared", ReadData1, 64'd0);
    next_cycle();
    RegWrite = 0;
    @(negedge clk);
    chk("t5_first_write", ReadData2, 64'h42);
    next_cycle();

    // 6: fill X1..X30 with index*0x1111
    for (int i = 1; i <= 30; i++) begin
      RegWrite = 1; WriteRegister = 5'(i); WriteData = 64'(i * 32'h1111);
      ReadRegister1 = 5'(i); ReadRegister2 = 5'(i - 1);
      next_cycle();
    end
    RegWrite = 0; ReadRegister1 = 1; ReadRegister2 = 30;
    @(negedge clk);
    chk("t6_x1", ReadData1, 64'h1111);
    chk("t6_x30", ReadData2, 64'h1FFFE);
    next_cycle();
    ReadRegister1 = 15; ReadRegister2 = 16;
    @(negedge clk);
    chk("t6_x15", ReadData1, 64'hFFFF);
    chk("t6_x16", ReadData2, 64'h11110);
    next_cycle();
    ReadRegister1 = 31; ReadRegister2 = 29;
    @(negedge clk);
    chk("t6_x31", ReadData1, 64'd0);
    chk("t6_x29", ReadData2, 64'h1EEED);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_regfile.md
Name: pipe_regfile

Overview:
- Architectural register file for the pipelined CPU: 32 x 64-bit registers, one write port, two read ports.
- Storage is clocked; the write port is driven from write-back and the read ports feed decode.
- It is the read side to the flip-flop storage: stored state is exposed to the pipeline with defined timing, a hard-wired zero register, and optional write-to-read bypass.

Parameters:
- DATA_WIDTH, 64, width of each register and data port.
- ADDR_WIDTH, 5, width of register index ports.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_WIDTH.
- ZERO_REG, 31, index of the hard-wired zero register (XZR).

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  synchronous, active-high; clears all registers.
- RegWrite  input  1  write enable from write-back stage.
- WriteRegister  input  ADDR_WIDTH  destination register index.
- WriteData  input  DATA_WIDTH  data to write.
- ReadRegister1  input  ADDR_WIDTH  read port 1 index.
- ReadRegister2  input  ADDR_WIDTH  read port 2 index.
- ReadData1  output  DATA_WIDTH  read port 1 data.
- ReadData2  output  DATA_WIDTH  read port 2 data.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high, sampled on posedge clk.
- Reset: at a posedge with reset=1, all NUM_REGS registers become 0. reset overrides RegWrite in the same cycle, so no write occurs. After the reset edge, ReadData1 = ReadData2 = 0 for every index.
- Write: at posedge clk with reset=0, RegWrite=1 and WriteRegister != ZERO_REG, reg[WriteRegister] <= WriteData.
- Write to ZERO_REG is silently discarded and its storage stays 0. No other register changes on any edge.
- Read: combinational, zero-cycle latency. ReadDataN = reg[ReadRegisterN], or 0 if ReadRegisterN == ZERO_REG.
- Both ports are fully independent. Identical indices on both ports return identical data.
- Read-after-write without bypass: a read of the register being written returns the old value until the write edge, and the new value from that edge onward.
- Mid-operation reset: asserting reset for one cycle between writes clears all prior writes. The first write after reset deasserts takes effect on the next edge.
- X-safety: out-of-range indices cannot occur, since NUM_REGS = 2**ADDR_WIDTH. Uninitialized simulation state before the first reset is permitted to be X.
- Structure: 32 DATA_WIDTH-wide flip-flop banks, a 5-to-32 write decoder gated by RegWrite, and two 32:1 read muxes.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: when reset=0, RegWrite=1, WriteRegister == ReadRegisterN and WriteRegister != ZERO_REG, ReadDataN = WriteData combinationally in the same cycle.
  - This removes the write-back to decode hazard.
  - Bypass is never applied to ZERO_REG reads, which still return 0.
  - Bypass is suppressed while reset=1.
- Not defined: no bypass; reads return stored contents only, as described in Behaviour.

Test Plan:
1. Reset, then a sweep of ReadRegister1/2 over 0..31 -> every read returns 0x0.
2. Write 0x0123456789ABCDEF to X5, next cycle read X5 on both ports -> both return 0x0123456789ABCDEF; reading X6 returns 0.
3. RegWrite=1, WriteRegister=31, WriteData=0xFFFFFFFFFFFFFFFF; then read X31 -> 0x0. No other register changes (spot-check X0 and X30 = 0).
4. With X7=0xAA, in one cycle write 0x55 to X7 while reading X7:
   - Without RF_BYPASS_EN, the read shows 0xAA before the edge and 0x55 after.
   - With RF_BYPASS_EN, the read shows 0x55 in the same cycle.
5. Assert reset and RegWrite together (WriteRegister=3, WriteData=0x99) -> X3 reads 0 after the edge. Registers written earlier (e.g. X5) also read 0.
6. Write X1..X30 with value = index*0x1111 on consecutive cycles, then read pairs (X1,X30), (X15,X16) -> returns 0x1111/0x1FFFE and 0xFFFF/0x11110.
